pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed EX/MEM latch. Carries a control vector, a destination register index, N data words and a side-band meta field between two pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer that keeps full throughput under back-pressure, a synchronous flush, and control gating so bubbles never write.
- Instantiated at the ID/EX, EX/MEM and MEM/WB boundaries.

Parameters:
- CTRL_W, 4, control-bit count (bit 0 RegWrite, 1 MemtoReg, 2 MemWrite, 3 MemRead for EX/MEM)
- DATA_W, 32, width of each data word
- NUM_DATA, 2, number of data words (ALUResult, WriteData for EX/MEM)
- RD_W, 5, destination-register index width
- META_W, 4, side-band width (Zero flag + funct3 for EX/MEM)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept an entry
- ctrl_in  in  CTRL_W  control bits
- data_in  in  NUM_DATA*DATA_W  data words, word 0 in the LSBs
- rd_in  in  RD_W  destination register
- meta_in  in  META_W  side-band
- out_valid  out  1  stage presents an entry
- out_ready  in  1  downstream accepts an entry
- ctrl_out  out  CTRL_W  control bits, forced to 0 when out_valid=0
- data_out  out  NUM_DATA*DATA_W  data words
- rd_out  out  RD_W  destination register
- meta_out  out  META_W  side-band

Behaviour:
- Storage: main entry (drives the outputs) plus skid entry. Each entry has its own valid bit.
- State encoding: EMPTY (none valid), ONE (main valid), TWO (main and skid valid).
- in_ready = !skid_valid. It is registered, has no combinational path from out_ready, and is 1 in EMPTY and ONE.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Transitions, evaluated with flush=0:
  - EMPTY: accept → ONE, main loaded.
  - ONE: accept & drain → ONE, main reloaded. accept & !drain → TWO, skid loaded. !accept & drain → EMPTY. Otherwise hold.
  - TWO: drain → ONE, skid moves to main (no accept is possible). Otherwise hold.
- Latency: entry accepted at edge k is visible at the outputs after edge k, with no back-pressure. Throughput is 1 entry/cycle.
- Payload registers load only on accept or skid→main. Held data stays stable while out_valid & !out_ready.
- ctrl_out = ctrl_q AND out_valid. data_out, rd_out and meta_out show the last held value when invalid; consumers ignore them.
- flush=1:
  - At the edge, both valid bits clear → EMPTY.
  - An input presented that cycle is discarded, even if in_ready=1.
  - A drain in the same cycle still counts as completed downstream.
- reset=1 (synchronous, priority over flush):
  - All valid bits and payload registers clear to 0, state EMPTY.
  - Outputs after the edge: out_valid=0, ctrl_out=0, data_out=0, rd_out=0, meta_out=0, in_ready=1.
  - A reset mid-transfer discards both entries.
- No width arithmetic; all fields pass through unmodified.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- When defined, the block adds the output ports stall_cnt[31:0] and bubble_cnt[31:0]:
  - stall_cnt increments each cycle out_valid & !out_ready.
  - bubble_cnt increments each cycle !out_valid.
  - Both saturate at 32'hFFFFFFFF and clear on reset only; flush does not clear them.
- When not defined, the ports and logic are absent and the stage behaves identically otherwise.

Decomposition:
- Package pipe_pkg holds:
  - the control-bit index constants CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMWRITE=2, CTRL_MEMREAD=3;
  - the 2-bit state encoding EMPTY=0, ONE=1, TWO=2;
  - the default widths.
- One sub-module, pipe_sat_counter (width-parametrised saturating counter), is instantiated twice under the macro.

Test Plan:
- Reset with reset=1 for 2 cycles while in_valid=1 → out_valid=0, ctrl_out=0, all payload 0, in_ready=1.
- Streaming: out_ready=1, in_valid=1, data_in word0 = 0x1000+k for k=0..7 → data_out word0 = 0x1000+k one cycle later, every cycle, in_ready stays 1.
- Back-pressure: out_ready=0 from cycle 2 while feeding 0xA, 0xB, 0xC:
  - 0xA is held at the output; 0xB goes to skid; in_ready=0 so 0xC stalls upstream.
  - After out_ready=1, the outputs show 0xA, 0xB, 0xC in order with no loss or duplication.
- Flush: flush=1 in state TWO with in_valid=1, ctrl_in=4'b0101 → next cycle out_valid=0, ctrl_out=0, in_ready=1, and the incoming entry never appears.
- Gating: one entry with ctrl_in=4'b1111, rd_in=5'd7 drained → next idle cycle ctrl_out=0 while rd_out still shows 7.
- Macro build: 5 stall cycles then 3 empty cycles → stall_cnt=5, bubble_cnt≥3; force the counter to 32'hFFFFFFFE, then 3 more stall cycles → stall_cnt=32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: control-bit indices, stage state encoding and default widths shared by pipeline stage registers
package pipe_pkg;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD = 3;
  localparam int DEF_CTRL_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_DATA = 2;
  localparam int DEF_RD_W = 5;
  localparam int DEF_META_W = 4;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: W-bit up counter that sticks at all-ones; ports clk, reset (sync clear), inc, count
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with 2-entry skid, sync flush and ctrl gating; ports clk, reset, flush, in_valid/in_ready + ctrl_in/data_in/rd_in/meta_in, out_valid/out_ready + ctrl_out/data_out/rd_out/meta_out; PIPE_STAGE_PERF_CNT_EN adds stall_cnt/bubble_cnt
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_DATA = DEF_NUM_DATA,
  parameter int RD_W = DEF_RD_W,
  parameter int META_W = DEF_META_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic [NUM_DATA*DATA_W-1:0] data_in,
  input  logic [RD_W-1:0]            rd_in,
  input  logic [META_W-1:0]          meta_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [NUM_DATA*DATA_W-1:0] data_out,
  output logic [RD_W-1:0]            rd_out,
  output logic [META_W-1:0]          meta_out
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                bubble_cnt
`endif
);
  localparam int PW = CTRL_W + NUM_DATA * DATA_W + RD_W + META_W;
  state_t state, state_n;
  logic [PW-1:0] main_q, skid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic accept, drain, load_main, load_skid, skid_to_main;
  assign out_valid = state != EMPTY;
  assign in_ready = state != TWO;
  assign accept = in_valid & in_ready;
  assign drain = out_valid & out_ready;
  always_comb begin
    state_n = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        state_n = accept ? ONE : EMPTY;
        load_main = accept;
      end
      ONE: begin
        state_n = accept ? (drain ? ONE : TWO) : (drain ? EMPTY : ONE);
        load_main = accept & drain;
        load_skid = accept & !drain;
      end
      TWO: begin
        state_n = drain ? ONE : TWO;
        skid_to_main = drain;
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      skid_to_main = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      if (load_main) main_q <= {ctrl_in, data_in, rd_in, meta_in};
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid) skid_q <= {ctrl_in, data_in, rd_in, meta_in};
    end
  assign {ctrl_q, data_out, rd_out, meta_out} = main_q;
  assign ctrl_out = ctrl_q & {CTRL_W{out_valid}};
`ifdef PIPE_STAGE_PERF_CNT_EN
  pipe_sat_counter #(.W(32)) u_stall (.clk(clk), .reset(reset), .inc(out_valid & !out_ready), .count(stall_cnt));
  pipe_sat_counter #(.W(32)) u_bubble (.clk(clk), .reset(reset), .inc(!out_valid), .count(bubble_cnt));
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [3:0] ctrl_in = '0, ctrl_out, meta_in = '0, meta_out;
  logic [63:0] data_in = '0, data_out;
  logic [4:0] rd_in = '0, rd_out;
  int checks = 0, failures = 0;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt, s0, b0;
`endif
  always #5 clk = ~clk;
  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .data_in(data_in), .rd_in(rd_in), .meta_in(meta_in),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out), .data_out(data_out),
    .rd_out(rd_out), .meta_out(meta_out)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic feed(input logic [31:0] w0, input logic [3:0] c);
    in_valid = 1'b1;
    data_in = {32'h0, w0};
    ctrl_in = c;
  endtask
  initial begin
    reset = 1'b1;
    feed(32'hDEAD, 4'hF);
    rd_in = 5'd3;
    meta_in = 4'h9;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ctrl_out", 64'(ctrl_out), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_rd_out", 64'(rd_out), 64'd0);
    check("rst_meta_out", 64'(meta_out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      feed(32'h1000 + 32'(k), 4'h1);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_word0", 64'(data_out[31:0]), 64'h1000 + 64'(k));
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 64'(out_valid), 64'd0);
    feed(32'hA, 4'h1);
    tick();
    out_ready = 1'b0;
    feed(32'hB, 4'h1);
    tick();
    check("bp_hold_a", 64'(data_out[31:0]), 64'hA);
    check("bp_in_ready0", 64'(in_ready), 64'd0);
    feed(32'hC, 4'h1);
    tick();
    check("bp_still_a", 64'(data_out[31:0]), 64'hA);
    check("bp_stall_c", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_b", 64'(data_out[31:0]), 64'hB);
    check("bp_in_ready1", 64'(in_ready), 64'd1);
    tick();
    check("bp_c", 64'(data_out[31:0]), 64'hC);
    check("bp_c_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    feed(32'h11, 4'h1);
    tick();
    feed(32'h22, 4'h1);
    tick();
    check("fl_two", 64'(in_ready), 64'd0);
    flush = 1'b1;
    feed(32'h33, 4'b0101);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ctrl", 64'(ctrl_out), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("fl_no_ghost", 64'(out_valid), 64'd0);
    check("fl_no_33", 64'(data_out[31:0] == 32'h33), 64'd0);
    feed(32'h44, 4'h1);
    tick();
    check("fl1_load", 64'(data_out[31:0]), 64'h44);
    flush = 1'b1;
    feed(32'h55, 4'h1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl1_valid", 64'(out_valid), 64'd0);
    tick();
    check("fl1_no_55", 64'(out_valid), 64'd0);
    feed(32'h66, 4'b1111);
    rd_in = 5'd7;
    meta_in = 4'h5;
    tick();
    check("gate_ctrl_on", 64'(ctrl_out), 64'hF);
    check("gate_rd_on", 64'(rd_out), 64'd7);
    check("gate_meta_on", 64'(meta_out), 64'h5);
    in_valid = 1'b0;
    tick();
    check("gate_ctrl_off", 64'(ctrl_out), 64'd0);
    check("gate_rd_kept", 64'(rd_out), 64'd7);
    out_ready = 1'b0;
    feed(32'h77, 4'h3);
    tick();
    feed(32'h88, 4'h3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", data_out, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("mid_rst_no_skid", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_PERF_CNT_EN
    out_ready = 1'b0;
    feed(32'h99, 4'h1);
    tick();
    in_valid = 1'b0;
    s0 = stall_cnt;
    repeat (5) tick();
    check("perf_stall5", 64'(stall_cnt - s0), 64'd5);
    out_ready = 1'b1;
    tick();
    b0 = bubble_cnt;
    repeat (3) tick();
    check("perf_bubble3", 64'(bubble_cnt - b0 >= 32'd3), 64'd1);
    out_ready = 1'b0;
    feed(32'hAA, 4'h1);
    tick();
    in_valid = 1'b0;
    force dut.u_stall.count = 32'hFFFFFFFE;
    #1;
    release dut.u_stall.count;
    repeat (3) tick();
    check("perf_sat", 64'(stall_cnt), 64'hFFFFFFFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
